// File: rtl/bayer_frame_source.sv
// Synthetic Bayer raw-frame generator.
// Emits framed pixel stream with blanking and test patterns.
module bayer_frame_source #(
  parameter int H_ACTIVE = 1280,
  parameter int V_ACTIVE = 960,
  parameter int H_BLANK  = 16,
  parameter int V_BLANK  = 4
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iStart,
  input  logic        iStop,
  input  logic [1:0]  iMode,
  output logic [11:0] oDATA,
  output logic        oDVAL,
  output logic [10:0] oX_Cont,
  output logic [10:0] oY_Cont,
  output logic        oFrameDone,
  output logic [15:0] oFrame_Cont,
  output logic        oBusy
);

  localparam int VB_LEN = V_BLANK * (H_ACTIVE + H_BLANK);
  localparam int CW     = $clog2(VB_LEN + 1);

  localparam logic [10:0]   X_LAST  = 11'(H_ACTIVE - 1);
  localparam logic [10:0]   Y_LAST  = 11'(V_ACTIVE - 1);
  localparam logic [CW-1:0] HB_LAST = CW'(H_BLANK - 1);
  localparam logic [CW-1:0] VB_LAST = CW'(VB_LEN - 1);
  localparam logic [CW-1:0] VB_PRE  = CW'(VB_LEN - 2);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACTIVE,
    S_HBLANK,
    S_VBLANK
  } state_t;

  state_t        state_q, state_d;
  logic [10:0]   x_q, x_d;
  logic [10:0]   y_q, y_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    mode_q, mode_d;
  logic          stop_q, stop_d;
  logic [11:0]   data_q, data_d;
  logic          dval_q, dval_d;
  logic          done_q, done_d;
  logic [15:0]   fcnt_q, fcnt_d;
  logic          busy_q, busy_d;

  function automatic logic [11:0] pattern(
    input logic [1:0]  m,
    input logic [10:0] x,
    input logic [10:0] y
  );
    logic [11:0] p;
    unique case (m)
      2'd0: begin
        unique case ({y[0], x[0]})
          2'b00:   p = 12'h800;
          2'b01:   p = 12'hF00;
          2'b10:   p = 12'h100;
          default: p = 12'h800;
        endcase
      end
      2'd1:    p = {x, 1'b0};
      2'd2:    p = {y, 1'b0};
      default: p = (x[3] ^ y[3]) ? 12'hFFF : 12'h000;
    endcase
    return p;
  endfunction

  // next-state, counters and registered-output staging
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    stop_d  = stop_q | iStop;
    done_d  = 1'b0;
    fcnt_d  = fcnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (iStart) begin
          state_d = S_ACTIVE;
          x_d     = 11'd0;
          y_d     = 11'd0;
          mode_d  = iMode;
        end
      end
      S_ACTIVE: begin
        if (x_q == X_LAST) begin
          state_d = S_HBLANK;
          x_d     = 11'd0;
          cnt_d   = '0;
        end else begin
          x_d = x_q + 11'd1;
        end
      end
      S_HBLANK: begin
        if (cnt_q == HB_LAST) begin
          if (y_q != Y_LAST) begin
            state_d = S_ACTIVE;
            y_d     = y_q + 11'd1;
          end else begin
            state_d = S_VBLANK;
            y_d     = 11'd0;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_VBLANK: begin
        if (cnt_q == VB_LAST) begin
          if (stop_q | iStop) begin
            state_d = S_IDLE;
            stop_d  = 1'b0;
          end else begin
            state_d = S_ACTIVE;
            x_d     = 11'd0;
            y_d     = 11'd0;
            mode_d  = iMode;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == VB_PRE) begin
            done_d = 1'b1;
            fcnt_d = fcnt_q + 16'd1;
          end
        end
      end
    endcase
    dval_d = (state_d == S_ACTIVE);
    data_d = dval_d ? pattern(mode_d, x_d, y_d) : 12'h000;
    busy_d = (state_d != S_IDLE);
  end

  // state and output registers, synchronous reset
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      cnt_q   <= '0;
      mode_q  <= '0;
      stop_q  <= 1'b0;
      data_q  <= '0;
      dval_q  <= 1'b0;
      done_q  <= 1'b0;
      fcnt_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      stop_q  <= stop_d;
      data_q  <= data_d;
      dval_q  <= dval_d;
      done_q  <= done_d;
      fcnt_q  <= fcnt_d;
      busy_q  <= busy_d;
    end
  end

  assign oDATA       = data_q;
  assign oDVAL       = dval_q;
  assign oX_Cont     = x_q;
  assign oY_Cont     = y_q;
  assign oFrameDone  = done_q;
  assign oFrame_Cont = fcnt_q;
  assign oBusy       = busy_q;

endmodule

// File: tb/tb_bayer_frame_source.sv
// Directed bench for bayer_frame_source.
// Small geometry: 8x4 active, 3 h-blank, 2 v-blank lines.
module tb_bayer_frame_source;

  logic        clk;
  logic        iRST;
  logic        iStart;
  logic        iStop;
  logic [1:0]  iMode;
  logic [11:0] oDATA;
  logic        oDVAL;
  logic [10:0] oX_Cont;
  logic [10:0] oY_Cont;
  logic        oFrameDone;
  logic [15:0] oFrame_Cont;
  logic        oBusy;

  int          checks;
  int          errors;
  logic [15:0] exp_frames;

  bayer_frame_source #(
    .H_ACTIVE(8),
    .V_ACTIVE(4),
    .H_BLANK (3),
    .V_BLANK (2)
  ) dut (
    .iCLK       (clk),
    .iRST       (iRST),
    .iStart     (iStart),
    .iStop      (iStop),
    .iMode      (iMode),
    .oDATA      (oDATA),
    .oDVAL      (oDVAL),
    .oX_Cont    (oX_Cont),
    .oY_Cont    (oY_Cont),
    .oFrameDone (oFrameDone),
    .oFrame_Cont(oFrame_Cont),
    .oBusy      (oBusy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  function automatic logic [11:0] pat(input int m, input int x, input int y);
    logic [10:0] xv;
    logic [10:0] yv;
    logic [11:0] p;
    xv = 11'(x);
    yv = 11'(y);
    case (m)
      0: begin
        case ({yv[0], xv[0]})
          2'b00:   p = 12'h800;
          2'b01:   p = 12'hF00;
          2'b10:   p = 12'h100;
          default: p = 12'h800;
        endcase
      end
      1:       p = {xv, 1'b0};
      2:       p = {yv, 1'b0};
      default: p = (xv[3] ^ yv[3]) ? 12'hFFF : 12'h000;
    endcase
    return p;
  endfunction

  // walks one 66-cycle frame starting at its first pixel
  task automatic run_frame(input int mode, input int stop_at,
                           input int start_at, input string tag);
    logic [34:0] got;
    logic [34:0] exp;
    logic [16:0] gd;
    logic [16:0] ed;
    int          ndv;
    int          line;
    int          pos;
    ndv = 0;
    for (int t = 0; t < 66; t++) begin
      iStop  = (t == stop_at);
      iStart = (t == start_at);
      line = t / 11;
      pos  = t % 11;
      if (line < 4 && pos < 8)
        exp = {1'b1, pat(mode, pos, line), 11'(pos), 11'(line)};
      else if (line < 4)
        exp = {1'b0, 12'h000, 11'd0, 11'(line)};
      else
        exp = '0;
      got = {oDVAL, oDATA, oX_Cont, oY_Cont};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL %s_pix t=%0d got %h exp %h", tag, t, got, exp);
      end
      if (t == 65) exp_frames = exp_frames + 16'd1;
      ed = {1'(t == 65), exp_frames};
      gd = {oFrameDone, oFrame_Cont};
      checks++;
      if (gd !== ed) begin
        errors++;
        $display("FAIL %s_done t=%0d got %h exp %h", tag, t, gd, ed);
      end
      checks++;
      if (oBusy !== 1'b1) begin
        errors++;
        $display("FAIL %s_busy t=%0d got %b exp 1", tag, t, oBusy);
      end
      if (oDVAL === 1'b1) ndv++;
      step();
    end
    iStop  = 1'b0;
    iStart = 1'b0;
    checks++;
    if (ndv != 32) begin
      errors++;
      $display("FAIL %s_dvcount got %0d exp 32", tag, ndv);
    end
  endtask

  task automatic test_reset();
    logic [52:0] got;
    iRST = 1'b1;
    step();
    step();
    got = {oDVAL, oDATA, oX_Cont, oY_Cont, oFrameDone, oFrame_Cont, oBusy};
    checks++;
    if (got !== '0) begin
      errors++;
      $display("FAIL reset_outputs got %h exp 0", got);
    end
    iRST = 1'b0;
    exp_frames = 16'd0;
  endtask

  task automatic test_start_ramp();
    logic [34:0] got;
    logic [34:0] exp;
    iMode  = 2'd1;
    iStart = 1'b1;
    step();
    iStart = 1'b0;
    for (int i = 0; i < 8; i++) begin
      got = {oDVAL, oDATA, oX_Cont, oY_Cont};
      exp = {1'b1, 12'(2 * i), 11'(i), 11'd0};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL ramp_row0 i=%0d got %h exp %h", i, got, exp);
      end
      step();
    end
    for (int i = 0; i < 3; i++) begin
      got = {oDVAL, oDATA, oX_Cont, oY_Cont};
      exp = {1'b0, 12'h000, 11'd0, 11'd0};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL ramp_hblank i=%0d got %h exp %h", i, got, exp);
      end
      step();
    end
    got = {oDVAL, oDATA, oX_Cont, oY_Cont};
    exp = {1'b1, 12'h000, 11'd0, 11'd1};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL ramp_row1 got %h exp %h", got, exp);
    end
  endtask

  task automatic test_reset_midframe();
    logic [52:0] got;
    iRST = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      got = {oDVAL, oDATA, oX_Cont, oY_Cont, oFrameDone, oFrame_Cont, oBusy};
      checks++;
      if (got !== '0) begin
        errors++;
        $display("FAIL midreset i=%0d got %h exp 0", i, got);
      end
    end
    iRST = 1'b0;
    exp_frames = 16'd0;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if ({oDVAL, oBusy, oFrameDone} !== 3'b000) begin
        errors++;
        $display("FAIL midreset_idle i=%0d got %b exp 000",
                 i, {oDVAL, oBusy, oFrameDone});
      end
    end
  endtask

  task automatic test_free_run();
    iMode  = 2'd2;
    iStart = 1'b1;
    step();
    iStart = 1'b0;
    for (int f = 0; f < 3; f++) run_frame(2, -1, -1, "freerun");
  endtask

  task automatic test_stop();
    run_frame(2, 24, -1, "stop");
    for (int i = 0; i < 15; i++) begin
      checks++;
      if ({oDVAL, oBusy, oFrameDone, oDATA} !== 15'd0) begin
        errors++;
        $display("FAIL stop_idle i=%0d got %b%b%b exp 000",
                 i, oDVAL, oBusy, oFrameDone);
      end
      step();
    end
  endtask

  task automatic test_start_stop();
    iMode  = 2'd0;
    iStart = 1'b1;
    iStop  = 1'b1;
    step();
    iStart = 1'b0;
    iStop  = 1'b0;
    iMode  = 2'd3;
    run_frame(0, -1, 3, "startstop");
    for (int i = 0; i < 10; i++) begin
      checks++;
      if ({oDVAL, oBusy, oFrameDone} !== 3'b000) begin
        errors++;
        $display("FAIL startstop_idle i=%0d got %b exp 000",
                 i, {oDVAL, oBusy, oFrameDone});
      end
      step();
    end
  endtask

  task automatic test_checker_wrap();
    force dut.fcnt_q = 16'hFFFF;
    step();
    release dut.fcnt_q;
    step();
    exp_frames = 16'hFFFF;
    checks++;
    if (oFrame_Cont !== 16'hFFFF) begin
      errors++;
      $display("FAIL preload got %h exp ffff", oFrame_Cont);
    end
    iMode  = 2'd3;
    iStart = 1'b1;
    iStop  = 1'b1;
    step();
    iStart = 1'b0;
    iStop  = 1'b0;
    run_frame(3, -1, -1, "checker");
    checks++;
    if ({oBusy, oFrame_Cont} !== 17'd0) begin
      errors++;
      $display("FAIL wrap_final got %h exp 0", {oBusy, oFrame_Cont});
    end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    exp_frames = 16'd0;
    iRST       = 1'b1;
    iStart     = 1'b0;
    iStop      = 1'b0;
    iMode      = 2'd0;
    step();
    test_reset();
    test_start_ramp();
    test_reset_midframe();
    test_free_run();
    test_stop();
    test_start_stop();
    test_checker_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
